// File: rtl/cache_fe_arbiter.sv
// cache_fe_arbiter: shares one cache front-end port between N_MASTERS
// requesters with round-robin arbitration. A grant is locked from the first
// valid cycle until the cache answers. A cache that answers in the request
// cycle sees no extra latency.
module cache_fe_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int FE_ADDR_W = 32,
    parameter int FE_DATA_W = 32,
    parameter int FE_NBYTES = FE_DATA_W / 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N_MASTERS-1:0]           s_valid,
    input  logic [N_MASTERS*FE_ADDR_W-1:0] s_addr,
    input  logic [N_MASTERS*FE_DATA_W-1:0] s_wdata,
    input  logic [N_MASTERS*FE_NBYTES-1:0] s_wstrb,
    output logic [N_MASTERS-1:0]           s_ready,
    output logic [FE_DATA_W-1:0]           s_rdata,
    output logic                           m_valid,
    output logic [FE_ADDR_W-1:0]           m_addr,
    output logic [FE_DATA_W-1:0]           m_wdata,
    output logic [FE_NBYTES-1:0]           m_wstrb,
    input  logic                           m_ready,
    input  logic [FE_DATA_W-1:0]           m_rdata,
    output logic                           busy
);

    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] prio_q, prio_d;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] act;
    logic             found;
    logic             route;

    // Pointer increment with an explicit wrap, so non-power-of-two counts work
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        if (int'(i) == N_MASTERS - 1) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    // Round-robin search: first valid requester at or after prio_q
    always_comb begin
        sel   = '0;
        found = 1'b0;
        cand  = prio_q;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (!found && s_valid[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
            cand = next_idx(cand);
        end
    end

    // Next-state, completion pulse and payload routing
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        prio_d  = prio_q;
        act     = grant_q;
        route   = 1'b0;
        m_valid = 1'b0;
        s_ready = '0;
        busy    = 1'b0;
        case (state_q)
            IDLE: begin
                act     = sel;
                route   = found;
                m_valid = found;
                if (found) begin
                    if (m_ready) begin
                        s_ready[sel] = 1'b1;
                        prio_d       = next_idx(sel);
                    end else begin
                        grant_d = sel;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                busy    = 1'b1;
                route   = 1'b1;
                m_valid = s_valid[grant_q];
                // A completion with no live request is ignored; the grant holds
                if (m_ready && m_valid) begin
                    s_ready[grant_q] = 1'b1;
                    prio_d           = next_idx(grant_q);
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset silences the port in the same cycle, abandoning any request
        if (reset) begin
            route   = 1'b0;
            m_valid = 1'b0;
            s_ready = '0;
            busy    = 1'b0;
        end
        m_addr  = route ? s_addr[int'(act)*FE_ADDR_W +: FE_ADDR_W]  : '0;
        m_wdata = route ? s_wdata[int'(act)*FE_DATA_W +: FE_DATA_W] : '0;
        m_wstrb = route ? s_wstrb[int'(act)*FE_NBYTES +: FE_NBYTES] : '0;
    end

    // Read data is broadcast unregistered; requesters qualify it with s_ready
    assign s_rdata = m_rdata;

    // State, grant and round-robin pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            prio_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
        end
    end

    // Cache must only signal completion against a live request
    a_ready_needs_valid: assert property (@(posedge clk) disable iff (reset) m_ready |-> m_valid);

    // At most one requester is completed per cycle
    a_ready_onehot: assert property (@(posedge clk) $onehot0(s_ready));

endmodule
